// File: rtl/graphics_block_reader_pkg.sv
// graphics_block_reader_pkg: shared constants, FSM states and pixel record for the 8x8 block reader.
// Sweep order and state encodings match the block plotter so both sides walk blocks identically.
package graphics_block_reader_pkg;
  localparam int COLOUR_W = 3;
  localparam int ADDR_W = 15;
  localparam logic [7:0] FB_W = 8'd160;
  localparam logic [7:0] FB_H = 8'd120;
  localparam int BLOCK_DIM = 8;
  localparam int BLOCK_PIX = 64;
  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] COLOUR_WHITE = 3'b111;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [7:0]          x;
    logic [7:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                clipped;
  } pix_t;
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
    return {y, x};
  endfunction
  function automatic logic off_screen(input logic [7:0] x, input logic [7:0] y);
    return x >= FB_W || y >= FB_H;
  endfunction
endpackage

// File: rtl/graphics_block_reader_if.sv
// graphics_block_reader_if: control, RAM read port and pixel stream of the block reader.
// master = the reader (drives status, RAM strobe/address, pixel stream); slave = its environment.
interface graphics_block_reader_if;
  import graphics_block_reader_pkg::*;
  logic                start;
  logic [7:0]          x_in;
  logic [7:0]          y_in;
  logic [COLOUR_W-1:0] bg_colour;
  logic                busy;
  logic                done;
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [COLOUR_W-1:0] mem_rdata;
  logic                pix_valid;
  logic                pix_ready;
  logic [7:0]          pix_x;
  logic [7:0]          pix_y;
  logic [COLOUR_W-1:0] pix_colour;
  logic                pix_clipped;
  logic [6:0]          fg_count;
  modport master (
    input  start, x_in, y_in, bg_colour, mem_rdata, pix_ready,
    output busy, done, mem_rd_en, mem_addr, pix_valid, pix_x, pix_y, pix_colour, pix_clipped, fg_count
  );
  modport slave (
    output start, x_in, y_in, bg_colour, mem_rdata, pix_ready,
    input  busy, done, mem_rd_en, mem_addr, pix_valid, pix_x, pix_y, pix_colour, pix_clipped, fg_count
  );
endinterface

// File: rtl/graphics_block_reader_fifo.sv
// graphics_block_reader_fifo: 2-entry pixel FIFO between the RAM return path and the pixel stream.
// Ports: clk/rst, push_i+din_i write, pop_i drops head, empty_o/count_o occupancy, head_o feeds pix_*.
module graphics_block_reader_fifo import graphics_block_reader_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  pix_t       din_i,
  input  logic       pop_i,
  output logic       empty_o,
  output logic [1:0] count_o,
  output pix_t       head_o
);
  pix_t       mem_q [2];
  logic       wr_q, rd_q;
  logic [1:0] count_q;
  logic       do_push, do_pop;
  assign do_pop  = pop_i && count_q != 2'd0;
  assign do_push = push_i && (count_q != 2'd2 || do_pop);
  assign empty_o = count_q == 2'd0;
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wr_q    <= wr_q ^ do_push;
      rd_q    <= rd_q ^ do_pop;
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/graphics_block_reader.sv
// graphics_block_reader: sweeps an 8x8 block through the framebuffer RAM and streams (x,y,colour),
// counting unclipped pixels that differ from the background key.
// Ports: clk/rst plain; bus_io (master) carries start/base/bg, busy/done, RAM read port, pixel stream, fg_count.
module graphics_block_reader import graphics_block_reader_pkg::*; (
  input logic                      clk,
  input logic                      rst,
  graphics_block_reader_if.master  bus_io
);
  state_t              state_q, state_d;
  logic [5:0]          c_q;
  logic [7:0]          xb_q, yb_q, cx, cy;
  logic [COLOUR_W-1:0] bg_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [6:0]          fg_q;
  logic                fly_v_q, fly_clip_q;
  logic [7:0]          fly_x_q, fly_y_q;
  pix_t                head, din;
  logic [1:0]          cnt;
  logic                empty, clip, issue, pop, accept;
  assign accept = state_q == IDLE && bus_io.start;
  assign cx     = xb_q + {5'd0, c_q[5:3]};
  assign cy     = yb_q + {5'd0, c_q[2:0]};
  assign clip   = off_screen(cx, cy);
  assign pop    = !empty && bus_io.pix_ready;
  // Occupancy after this cycle's pop, counting the slot already in flight, stays below 2 so the
  // pixel issued now always finds room when it lands in the FIFO two edges later.
  assign issue  = state_q == READ && (3'(cnt) + 3'(fly_v_q) - 3'(pop)) < 3'd2;
  // Clipped pixels ride the in-flight slot too, so order is kept without a RAM read.
  assign din    = '{x: fly_x_q, y: fly_y_q, colour: fly_clip_q ? '0 : bus_io.mem_rdata, clipped: fly_clip_q};
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus_io.start ? READ : IDLE;
      READ:    state_d = issue && c_q == 6'(BLOCK_PIX - 1) ? DRAIN : READ;
      // Leave as the last pixel is being accepted so done follows the final handshake directly.
      DRAIN:   state_d = !fly_v_q && cnt == {1'b0, pop} ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      addr_q  <= '0;
      fly_v_q <= 1'b0;
      fg_q    <= '0;
    end else begin
      state_q <= state_d;
      fly_v_q <= issue;
      if (bus_io.mem_rd_en) addr_q <= bus_io.mem_addr;
      if (accept) begin
        c_q  <= '0;
        fg_q <= '0;
      end else begin
        if (issue) c_q <= c_q + 6'd1;
        if (pop && !head.clipped && head.colour != bg_q) fg_q <= fg_q + 7'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      xb_q <= bus_io.x_in;
      yb_q <= bus_io.y_in;
      bg_q <= bus_io.bg_colour;
    end
    fly_x_q    <= cx;
    fly_y_q    <= cy;
    fly_clip_q <= clip;
  end
  graphics_block_reader_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fly_v_q),
    .din_i   (din),
    .pop_i   (pop),
    .empty_o (empty),
    .count_o (cnt),
    .head_o  (head)
  );
  assign bus_io.busy        = state_q == READ || state_q == DRAIN;
  assign bus_io.done        = state_q == DONE;
  assign bus_io.mem_rd_en   = issue && !clip;
  assign bus_io.mem_addr    = bus_io.mem_rd_en ? fb_addr(cx, cy[6:0]) : addr_q;
  assign bus_io.pix_valid   = !empty;
  assign bus_io.pix_x       = head.x;
  assign bus_io.pix_y       = head.y;
  assign bus_io.pix_colour  = head.colour;
  assign bus_io.pix_clipped = head.clipped;
  assign bus_io.fg_count    = fg_q;
endmodule
